// File: rtl/dot_matrix_scan_if.sv
// Bus between the fan-pattern generator and the LED matrix row-scan driver.
// master: frame source and pin observer; slave: the scan driver.
interface dot_matrix_scan_if;
  logic        enable;
  logic [63:0] frame_R;
  logic [63:0] frame_G;
  logic [7:0]  row;
  logic [7:0]  col_R;
  logic [7:0]  col_G;
  logic [2:0]  row_idx;
  logic        frame_start;

  modport master (
    output enable, frame_R, frame_G,
    input  row, col_R, col_G, row_idx, frame_start
  );

  modport slave (
    input  enable, frame_R, frame_G,
    output row, col_R, col_G, row_idx, frame_start
  );
endinterface

// File: rtl/dot_matrix_scan.sv
// Row-scanning driver for an 8x8 bicolour LED matrix. Frames are double-buffered
// into shadow registers at the frame boundary; each row slot starts with a
// blanking interval. Outputs are registered from next-state values, so they
// reflect the (cnt, ridx) held in the same cycle with no extra lag.
module dot_matrix_scan #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned BLANK_CYCLES   = 20,
  parameter bit          ROW_ACTIVE_LOW = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  dot_matrix_scan_if.slave bus_io
);

  localparam int unsigned    CntW     = $clog2(SCAN_DIV);
  localparam logic [CntW-1:0] CntMax   = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYCLES);
  localparam logic [7:0]      RowOff   = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {StIdle, StBlank, StDrive} mode_e;

  mode_e           mode_q, mode_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      ridx_q, ridx_d;
  logic [63:0]     shadow_r_q, shadow_r_d;
  logic [63:0]     shadow_g_q, shadow_g_d;
  logic            frame_load;

  logic [7:0]      row_q, row_d;
  logic [7:0]      col_r_q, col_r_d;
  logic [7:0]      col_g_q, col_g_d;
  logic [2:0]      row_idx_q;
  logic            frame_start_q, frame_start_d;

  logic [7:0]      row_sel;
  logic [5:0]      col_base;

  // Next-state: counter/row advance, mode decode and shadow capture.
  always_comb begin
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    ridx_d     = ridx_q;
    shadow_r_d = shadow_r_q;
    shadow_g_d = shadow_g_q;
    frame_load = 1'b0;
    if (!bus_io.enable) begin
      mode_d = StIdle;
      cnt_d  = '0;
      ridx_d = '0;
    end else begin
      if (mode_q == StIdle) begin
        cnt_d      = '0;
        ridx_d     = '0;
        frame_load = 1'b1;
      end else if (cnt_q == CntMax) begin
        cnt_d      = '0;
        ridx_d     = ridx_q + 3'd1;
        // Wrap back to row 0 is the frame boundary.
        frame_load = (ridx_q == 3'd7);
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
      mode_d = (cnt_d < BlankEnd) ? StBlank : StDrive;
      if (frame_load) begin
        shadow_r_d = bus_io.frame_R;
        shadow_g_d = bus_io.frame_G;
      end
    end
  end

  // Row r lives in bits [63-8r : 56-8r]; base offset 8*(7-r) equals {~r, 3'b000}.
  assign row_sel  = 8'b1 << ridx_d;
  assign col_base = {~ridx_d, 3'b000};

  // Output decode from next-state values.
  always_comb begin
    row_d         = RowOff;
    col_r_d       = 8'h00;
    col_g_d       = 8'h00;
    frame_start_d = (mode_d != StIdle) && (ridx_d == 3'd0) && (cnt_d == '0);
    if (mode_d == StDrive) begin
      row_d   = ROW_ACTIVE_LOW ? ~row_sel : row_sel;
      col_r_d = shadow_r_d[col_base +: 8];
      col_g_d = shadow_g_d[col_base +: 8];
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q        <= StIdle;
      cnt_q         <= '0;
      ridx_q        <= '0;
      shadow_r_q    <= '0;
      shadow_g_q    <= '0;
      row_q         <= RowOff;
      col_r_q       <= 8'h00;
      col_g_q       <= 8'h00;
      row_idx_q     <= 3'd0;
      frame_start_q <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      cnt_q         <= cnt_d;
      ridx_q        <= ridx_d;
      shadow_r_q    <= shadow_r_d;
      shadow_g_q    <= shadow_g_d;
      row_q         <= row_d;
      col_r_q       <= col_r_d;
      col_g_q       <= col_g_d;
      row_idx_q     <= ridx_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus_io.row         = row_q;
  assign bus_io.col_R       = col_r_q;
  assign bus_io.col_G       = col_g_q;
  assign bus_io.row_idx     = row_idx_q;
  assign bus_io.frame_start = frame_start_q;

endmodule

// File: doc/dot_matrix_scan.md
# dot_matrix_scan

Row-scanning driver for the 8×8 bicolour (red/green) LED matrix on the fan-controller board. It sits directly downstream of the fan-pattern generator and consumes its two 64-bit frame words (red and green). It time-multiplexes those words onto the physical row-select and column pins, one row at a time. Frames are double-buffered at the frame boundary so a pattern change never tears mid-scan, and a blanking interval at each row change suppresses ghosting.

## Interface
Parameters:
- SCAN_DIV, 1000: clock cycles per row slot. Legal range is ≥ 2.
- BLANK_CYCLES, 20: cycles at the start of each row slot during which all rows and columns are off. Legal range is 1 ≤ BLANK_CYCLES < SCAN_DIV.
- ROW_ACTIVE_LOW, 1: 1 means a selected row pin is driven 0; 0 means a selected row pin is driven 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  1 = scan the matrix; 0 = display dark.
- frame_R  in  64  red frame from the pattern generator.
- frame_G  in  64  green frame from the pattern generator.
- row  out  8  row-select pins; row[r] drives matrix row r, with row 0 at the top.
- col_R  out  8  red column pins, active-high.
- col_G  out  8  green column pins, active-high.
- row_idx  out  3  index of the row currently being scanned.
- frame_start  out  1  one-cycle pulse at the start of each frame.

## Operation
- Frame bit mapping: row r takes bits [63-8r : 56-8r]. The MSB of each byte is the leftmost column and maps to col_x[7]. Columns are copied byte-for-byte with no reordering.
- Internal state:
  - cnt: 0..SCAN_DIV-1.
  - ridx: 0..7.
  - shadow_R / shadow_G: 64 bits each.
  - mode: one of IDLE, BLANK, DRIVE.
- IDLE:
  - Entered on reset, or at the next edge after enable is sampled 0 in any mode.
  - cnt and ridx are cleared; the shadow registers are retained.
  - Outputs are off: all rows inactive, col_R and col_G = 0, frame_start = 0.
- IDLE → BLANK when enable is sampled 1. At that edge:
  - cnt = 0 and ridx = 0.
  - frame_R and frame_G are captured into the shadow registers.
- BLANK: covers cnt < BLANK_CYCLES. Rows are inactive and columns are 0.
- DRIVE: covers cnt ≥ BLANK_CYCLES.
  - row[ridx] is active and all other rows are inactive.
  - col_R = shadow_R row ridx; col_G = shadow_G row ridx.
- Counter advance:
  - Each enabled cycle, cnt increments.
  - When cnt = SCAN_DIV-1, cnt wraps to 0 and ridx increments. ridx wraps from 7 to 0.
  - A wrap to ridx = 0 is a frame boundary: the shadow registers are reloaded from the inputs at that same edge.
- Shadow loading: the shadow registers load only at a frame boundary or at IDLE exit. Input changes at any other time have no visible effect until the next frame.
- frame_start = 1 exactly in the cycles where mode ≠ IDLE, ridx = 0 and cnt = 0.
- row_idx = ridx in all modes, so it reads 0 in IDLE.
- Row polarity: an active row is driven 0 if ROW_ACTIVE_LOW, else 1; inactive rows take the opposite level.

## Timing
- All outputs are registered. They are computed from next-state values, so in the clock cycle where the state holds cnt = k and ridx = r, the outputs already reflect that (k, r). There is no additional lag.
- Reset values (asynchronous): row = 8'hFF if ROW_ACTIVE_LOW else 8'h00; col_R = 0; col_G = 0; row_idx = 0; frame_start = 0; mode = IDLE; shadow = 0.
- Cycle numbering: cycle 0 is the first cycle after the edge that samples enable = 1 in IDLE.
  - Row r is blanked in cycles r·SCAN_DIV through r·SCAN_DIV+BLANK_CYCLES-1.
  - Row r is driven in cycles r·SCAN_DIV+BLANK_CYCLES through (r+1)·SCAN_DIV-1.
  - A frame lasts 8·SCAN_DIV cycles.
- The shadow capture at cycle 0 of each frame samples the inputs present on the preceding edge. Because cycle 0 is always blanked, the new shadow is first visible at cycle BLANK_CYCLES.
- enable falling mid-row: the next cycle is IDLE and dark, with no partial completion of the row. A later rise restarts at row 0 with a fresh capture.
- rst_n asserted mid-frame: all outputs go to their reset values immediately (asynchronously). Scanning restarts from IDLE once rst_n is released.
- Adjacent rows are never active in the same cycle. At least BLANK_CYCLES dark cycles separate any two driven rows.

## Test plan
Parameters for all scenarios: SCAN_DIV = 8, BLANK_CYCLES = 2, ROW_ACTIVE_LOW = 1.
- Reset state: hold rst_n = 0 → row = FF, col_R = col_G = 00, frame_start = 0, row_idx = 0. Release rst_n with enable = 0 → outputs unchanged.
- Basic scan: frame_R = 64'h0103070810E0C080, frame_G = 64'hE060201008040607, enable rises.
  - Cycles 0–1: row = FF, columns 00, frame_start = 1 in cycle 0 only.
  - Cycles 2–7: row = FE, col_R = 01, col_G = E0.
  - Cycles 42–47: row = DF, col_R = E0, col_G = 04, row_idx = 5.
  - Cycle 64: frame_start = 1 and row_idx = 0.
- Tear-free update: change frame_R to 64'h0000004FF2000000 at cycle 20.
  - Row 3 (cycles 26–31) still shows col_R = 08.
  - From cycle 64 on, the new frame is used: row 3 shows col_R = 4F in cycles 90–95.
- Enable drop: drop enable at cycle 30 → from the next cycle, row = FF, columns 00, row_idx = 0. Raise enable again → scanning restarts at row 0 with frame_start = 1.
- Reset mid-frame: assert rst_n at cycle 45 → outputs reach reset values without waiting for a clock edge. Release rst_n with enable = 1 → scan restarts at row 0.
- Polarity and wrap: set ROW_ACTIVE_LOW = 0 and run 3 frames.
  - At most one row bit is ever 1.
  - Row 7 is followed by 2 dark cycles, then row 0.
  - row_idx sequence is 0..7,0.
